// File: rtl/wbpwmaudio_mc.sv
// Multi-channel Wishbone audio output: frame FIFO drained by a sample
// timer, each channel rendered as bit-reversed PWM or first-order PDM.
module wbpwmaudio_mc #(
  parameter int NCH = 2,
  parameter int DW = 16,
  parameter int FIFO_AW = 3,
  parameter int RW = 16,
  parameter int unsigned DEFAULT_RELOAD = 2267
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_wb_cyc,
  input  logic           i_wb_stb,
  input  logic           i_wb_we,
  input  logic [1:0]     i_wb_addr,
  input  logic [31:0]    i_wb_data,
  input  logic [3:0]     i_wb_sel,
  output logic           o_wb_stall,
  output logic           o_wb_ack,
  output logic [31:0]    o_wb_data,
  output logic [NCH-1:0] o_pwm,
  output logic           o_shutdown_n,
  output logic           o_int
);

  localparam int FW = NCH * DW;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] HALF_CNT = (FIFO_AW+1)'(DEPTH / 2);
  localparam logic [RW-1:0] RST_RELOAD = RW'(DEFAULT_RELOAD);

  logic              en, mode, irq_en;
  logic              flush_q, underrun, overflow, tick;
  logic [RW-1:0]     reload, timer;
  logic [FW-1:0]     mem [DEPTH];
  logic [FW-1:0]     head;
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0]  cnt;
  logic [DW-1:0]     smp [NCH];
  logic [DW-1:0]     u [NCH];
  logic [DW:0]       acc [NCH];
  logic [DW-1:0]     pcnt, pcnt_rev;
  logic [31:0]       rd_data;

  logic req, wr, push, push_ok, pop_ok;
  logic empty, full;
  logic unused_sel;

  assign req = i_wb_cyc & i_wb_stb;
  assign wr = req & i_wb_we;
  assign empty = (cnt == '0);
  assign full = (cnt == FULL_CNT);
  assign push = wr & (i_wb_addr == 2'd0) & ~flush_q;
  assign pop_ok = tick & ~empty & ~flush_q;
  assign push_ok = push & (~full | pop_ok);
  assign head = mem[rp];

  assign o_wb_stall = 1'b0;
  assign o_shutdown_n = en;
  assign unused_sel = ^i_wb_sel;

  always_comb begin
    rd_data = '0;
    case (i_wb_addr)
      2'd1: rd_data[RW-1:0] = reload;
      2'd2: rd_data[2:0] = {irq_en, mode, en};
      2'd3: begin
        rd_data[3:0] = {full, empty, overflow, underrun};
        rd_data[8 +: FIFO_AW+1] = cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
      reload    <= RST_RELOAD;
      en        <= 1'b0;
      mode      <= 1'b0;
      irq_en    <= 1'b0;
      flush_q   <= 1'b0;
      underrun  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      o_wb_ack <= req;
      flush_q  <= 1'b0;
      if (req)
        o_wb_data <= rd_data;
      if (wr && i_wb_addr == 2'd1)
        for (int i = 0; i < RW; i++)
          if (i_wb_sel[i/8]) reload[i] <= i_wb_data[i];
      if (wr && i_wb_addr == 2'd2 && i_wb_sel[0]) begin
        en      <= i_wb_data[0];
        mode    <= i_wb_data[1];
        irq_en  <= i_wb_data[2];
        flush_q <= i_wb_data[3];
      end
      if (wr && i_wb_addr == 2'd3 && i_wb_sel[0]) begin
        if (i_wb_data[0]) underrun <= 1'b0;
        if (i_wb_data[1]) overflow <= 1'b0;
      end
      // Hardware set beats a same-cycle software clear
      if (tick && empty && !flush_q) underrun <= 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wp] <= i_wb_data[FW-1:0];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush_q) begin
      rp  <= wp;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + FIFO_AW'(1);
      if (pop_ok) rp <= rp + FIFO_AW'(1);
      cnt <= cnt + {{FIFO_AW{1'b0}}, push_ok}
                 - {{FIFO_AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      timer <= RST_RELOAD;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (!en) begin
        timer <= reload;
      end else if (timer == '0) begin
        timer <= reload;
        tick  <= 1'b1;
      end else begin
        timer <= timer - RW'(1);
      end
    end
  end

  always_comb begin
    pcnt_rev = '0;
    for (int i = 0; i < DW; i++)
      pcnt_rev[i] = pcnt[DW-1-i];
  end

  always_comb begin
    u = '{default: '0};
    for (int k = 0; k < NCH; k++)
      u[k] = {~smp[k][DW-1], smp[k][DW-2:0]};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pcnt  <= '0;
      o_pwm <= '0;
      o_int <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        smp[k] <= '0;
        acc[k] <= '0;
      end
    end else begin
      o_int <= irq_en & en & (cnt <= HALF_CNT);
      for (int k = 0; k < NCH; k++)
        if (pop_ok) smp[k] <= head[k*DW +: DW];
      if (!en) begin
        o_pwm <= '0;
        for (int k = 0; k < NCH; k++)
          acc[k] <= '0;
      end else begin
        pcnt <= pcnt + DW'(1);
        for (int k = 0; k < NCH; k++) begin
          acc[k] <= {1'b0, acc[k][DW-1:0]} + {1'b0, u[k]};
          o_pwm[k] <= mode ? acc[k][DW] : (u[k] > pcnt_rev);
        end
      end
    end
  end

endmodule

// File: tb/tb_wbpwmaudio_mc.sv
// Scoreboard bench for wbpwmaudio_mc: bus reads/acks checked by a monitor,
// PWM/PDM/interrupt behaviour checked with directed vectors.
module tb_wbpwmaudio_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]  adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        stall, ack, shdn_n, irq;
  logic [31:0] rdat;
  logic [1:0]  pwm;

  int n_chk = 0;
  int n_fail = 0;
  int cyc_cnt = 0;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  wbpwmaudio_mc dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(adr), .i_wb_data(dat), .i_wb_sel(sel),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(rdat),
    .o_pwm(pwm), .o_shutdown_n(shdn_n), .o_int(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (rst_n && ack) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: ack at cycle %0d, none pending", cyc_cnt);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc_cnt || (mon_e.chk && rdat !== mon_e.exp)) begin
          n_fail++;
          $display("FAIL %s: ack cycle %0d data %08h, expected cycle %0d data %08h",
                   mon_e.nm, cyc_cnt, rdat, mon_e.cyc, mon_e.exp);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic c, input logic [31:0] e,
                     input string nm);
    exp_t x;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    x.chk = c; x.exp = e; x.cyc = cyc_cnt + 1; x.nm = nm;
    sb.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 4'hf, 1'b0, 32'h0, "write_ack");
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    bus(1'b0, a, 32'h0, 4'hf, 1'b1, e, nm);
  endtask

  task automatic idle(input int n);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int h0, h1, tog, ones1;
  logic prev;

  initial begin
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_pwm", {30'b0, pwm}, 0);
    check("rst_shdn", {31'b0, shdn_n}, 0);
    check("rst_int", {31'b0, irq}, 0);
    check("rst_ack", {31'b0, ack}, 0);
    rd(2'd3, 32'h0000_0004, "rst_status");
    rd(2'd1, 32'd2267, "rst_reload");
    rd(2'd2, 32'h0, "rst_ctrl");
    rd(2'd0, 32'h0, "fifo_read_zero");
    idle(2);

    bus(1'b1, 2'd1, 32'h0000_ffff, 4'b0001, 1'b0, 32'h0, "write_ack");
    rd(2'd1, 32'h0000_08ff, "reload_byte_sel");
    idle(1);

    for (int i = 0; i < 9; i++) wr(2'd0, 32'h1111_0000 + i);
    rd(2'd3, 32'h0000_080a, "status_full_ovf");
    wr(2'd3, 32'h2);
    rd(2'd3, 32'h0000_0808, "status_ovf_w1c");
    wr(2'd2, 32'h8);
    wr(2'd0, 32'hdead_beef);
    rd(2'd3, 32'h0000_0004, "flush_when_full");
    rd(2'd2, 32'h0, "flush_reads_0");
    idle(2);

    wr(2'd1, 32'd9);
    rd(2'd1, 32'd9, "reload_9");
    wr(2'd0, 32'h4000_c000);
    wr(2'd2, 32'h1);
    idle(30);
    h0 = 0; h1 = 0;
    repeat (65536) begin
      @(negedge clk);
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
    end
    @(posedge clk); #1;
    check("pwm_duty_ch0", h0, 16384);
    check("pwm_duty_ch1", h1, 49152);
    check("shdn_en", {31'b0, shdn_n}, 1);
    check("int_disabled", {31'b0, irq}, 0);
    rd(2'd3, 32'h0000_0005, "status_underrun");

    wr(2'd2, 32'h5);
    for (int i = 0; i < 5; i++) wr(2'd0, 32'h1234_5678 + i);
    wr(2'd0, 32'h8000_0000);
    idle(2);
    check("int_fill_high", {31'b0, irq}, 0);
    idle(100);
    check("int_fill_low", {31'b0, irq}, 1);
    rd(2'd3, 32'h0000_0005, "drain_underrun");

    wr(2'd2, 32'h7);
    idle(3);
    tog = 0; ones1 = 0;
    @(negedge clk);
    prev = pwm[0];
    ones1 += int'(pwm[1]);
    repeat (16) begin
      @(negedge clk);
      if (pwm[0] != prev) tog++;
      prev = pwm[0];
      ones1 += int'(pwm[1]);
    end
    @(posedge clk); #1;
    check("pdm_half_toggle", tog, 16);
    check("pdm_zero_const", ones1, 0);

    wr(2'd2, 32'h0);
    idle(2);
    check("dis_pwm", {30'b0, pwm}, 0);
    check("dis_shdn", {31'b0, shdn_n}, 0);
    check("dis_int", {31'b0, irq}, 0);

    wr(2'd3, 32'h3);
    rd(2'd3, 32'h0000_0004, "status_clear");
    for (int i = 0; i < 3; i++) wr(2'd0, 32'h0101_0000 + i);
    rd(2'd3, 32'h0000_0300, "fill3");
    wr(2'd2, 32'h8);
    wr(2'd0, 32'hcafe_f00d);
    rd(2'd3, 32'h0000_0004, "flush_vs_push");
    rd(2'd2, 32'h0, "flush_self_clear");
    idle(2);

    wr(2'd2, 32'h1);
    wr(2'd0, 32'h0000_0000);
    wr(2'd0, 32'h0000_0000);
    idle(30);
    rst_n = 1'b0;
    #1;
    check("async_pwm", {30'b0, pwm}, 0);
    check("async_shdn", {31'b0, shdn_n}, 0);
    check("async_ack", {31'b0, ack}, 0);
    #16 rst_n = 1'b1;
    @(posedge clk); #1;
    rd(2'd3, 32'h0000_0004, "post_rst_status");
    rd(2'd1, 32'd2267, "post_rst_reload");
    rd(2'd2, 32'h0, "post_rst_ctrl");
    idle(3);
    check("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
